// File: rtl/ctl_seq.sv
// ctl_seq: registered EBOX CTL decode with PI-cycle flag-save sequencer
module ctl_seq #(
    parameter int WIDTH    = 36,
    parameter int LSEG     = 9,
    parameter int LCLR     = 12,
    parameter int SELW     = 3,
    parameter int SAVE_CYC = 2
) (
    input  logic            eboxClk,
    input  logic            eboxResetN,
    input  logic            cramValid,
    input  logic [SELW-1:0] cramARL,
    input  logic [SELW-1:0] cramARR,
    input  logic [SELW-1:0] cramARX,
    input  logic [2:0]      cramARclr,
    input  logic            cramADcarry,
    input  logic            specXCRY_AR0,
    input  logic            specGenCarry18,
    input  logic            specInhCarry18,
    input  logic            specADlong,
    input  logic            EDP_AR0,
    input  logic            PCplus1inh,
    output logic [2:0]      CTL_ARload,
    output logic [2:0]      CTL_ARclr,
    output logic [SELW-1:0] CTL_ARL_SEL,
    output logic [SELW-1:0] CTL_ARR_SEL,
    output logic [SELW-1:0] CTL_ARX_SEL,
    output logic            CTL_ARX_LOAD,
    output logic            CTL_ADcarry36,
    output logic            CTL_ADXcarry36,
    output logic            CTL_ADlong,
    output logic            CTL_inhibitCarry18,
    output logic            CTL_SPEC_genCarry18,
    output logic            CTL_saveBusy,
    output logic            CTL_saveDone
);
    if (WIDTH < 8 || WIDTH % 2 != 0 || LSEG >= WIDTH / 2 || LCLR >= WIDTH / 2 || SAVE_CYC < 1) begin : g_bad_params
        $error("ctl_seq: illegal WIDTH/LSEG/LCLR/SAVE_CYC");
    end

    localparam int CW = $clog2(SAVE_CYC + 1);

    typedef enum logic [1:0] {IDLE, SAVE, DONE} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          pi_save, go;
    logic [2:0]    load_n;
    logic          adx_n;

    // next state, save counter, and load/ADX values with clear-wins and save suppression
    always_comb begin
        pi_save = PCplus1inh & specXCRY_AR0;
        go      = cramValid & pi_save;
        state_n = state;
        cnt_n   = cnt;
        case (state)
            IDLE: begin
                state_n = go ? SAVE : IDLE;
                cnt_n   = go ? CW'(SAVE_CYC - 1) : cnt;
            end
            SAVE: begin
                state_n = (cnt == '0) ? DONE : SAVE;
                cnt_n   = (cnt == '0) ? cnt : cnt - CW'(1);
            end
            DONE: begin
                state_n = go ? SAVE : IDLE;
                cnt_n   = go ? CW'(SAVE_CYC - 1) : cnt;
            end
            default: state_n = IDLE;
        endcase
        load_n = (cramValid && state_n != SAVE) ? ({|cramARL, |cramARL, |cramARR} & ~cramARclr) : 3'b000;
        adx_n  = cramValid & ~pi_save & (state_n != SAVE) & ((EDP_AR0 & specXCRY_AR0) ^ cramADcarry);
    end

    // register FSM state and every output one cycle after the microword
    always_ff @(posedge eboxClk) begin
        if (!eboxResetN) begin
            state               <= IDLE;
            cnt                 <= '0;
            CTL_ARload          <= '0;
            CTL_ARclr           <= '0;
            CTL_ARL_SEL         <= '0;
            CTL_ARR_SEL         <= '0;
            CTL_ARX_SEL         <= '0;
            CTL_ARX_LOAD        <= 1'b0;
            CTL_ADcarry36       <= 1'b0;
            CTL_ADXcarry36      <= 1'b0;
            CTL_ADlong          <= 1'b0;
            CTL_inhibitCarry18  <= 1'b0;
            CTL_SPEC_genCarry18 <= 1'b0;
            CTL_saveBusy        <= 1'b0;
            CTL_saveDone        <= 1'b0;
        end else begin
            state               <= state_n;
            cnt                 <= cnt_n;
            CTL_ARload          <= load_n;
            CTL_ARclr           <= cramValid ? cramARclr : 3'b000;
            CTL_ARL_SEL         <= cramValid ? cramARL : CTL_ARL_SEL;
            CTL_ARR_SEL         <= cramValid ? cramARR : CTL_ARR_SEL;
            CTL_ARX_SEL         <= cramValid ? cramARX : CTL_ARX_SEL;
            CTL_ARX_LOAD        <= cramValid & |cramARX;
            CTL_ADcarry36       <= cramValid & cramADcarry;
            CTL_ADXcarry36      <= adx_n;
            CTL_ADlong          <= cramValid & specADlong;
            CTL_inhibitCarry18  <= cramValid & specInhCarry18 & ~specADlong;
            CTL_SPEC_genCarry18 <= cramValid & specGenCarry18 & ~specInhCarry18;
            CTL_saveBusy        <= state_n == SAVE;
            CTL_saveDone        <= state_n == DONE;
        end
    end
endmodule

// File: tb/tb_ctl_seq.sv
// tb_ctl_seq: scoreboard bench for ctl_seq with a timeline-based reference model
module tb_ctl_seq;
    localparam int SELW     = 3;
    localparam int SAVE_CYC = 2;

    typedef struct packed {
        logic [2:0] ld;
        logic [2:0] clr;
        logic [2:0] arl;
        logic [2:0] arr;
        logic [2:0] arx;
        logic       arxld;
        logic       adc;
        logic       adx;
        logic       along;
        logic       inh;
        logic       gen;
        logic       busy;
        logic       done;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rstn, valid, adc, xcry, gen18, inh18, adlong, ar0, pcinh;
    logic [SELW-1:0] arl, arr, arx;
    logic [2:0]      clr;

    logic [2:0]      o_ld, o_clr;
    logic [SELW-1:0] o_arl, o_arr, o_arx;
    logic            o_arxld, o_adc, o_adx, o_along, o_inh, o_gen, o_busy, o_done;

    ctl_seq #(.WIDTH(36), .LSEG(9), .LCLR(12), .SELW(SELW), .SAVE_CYC(SAVE_CYC)) dut (
        .eboxClk(clk), .eboxResetN(rstn), .cramValid(valid),
        .cramARL(arl), .cramARR(arr), .cramARX(arx), .cramARclr(clr),
        .cramADcarry(adc), .specXCRY_AR0(xcry), .specGenCarry18(gen18),
        .specInhCarry18(inh18), .specADlong(adlong), .EDP_AR0(ar0), .PCplus1inh(pcinh),
        .CTL_ARload(o_ld), .CTL_ARclr(o_clr), .CTL_ARL_SEL(o_arl), .CTL_ARR_SEL(o_arr),
        .CTL_ARX_SEL(o_arx), .CTL_ARX_LOAD(o_arxld), .CTL_ADcarry36(o_adc),
        .CTL_ADXcarry36(o_adx), .CTL_ADlong(o_along), .CTL_inhibitCarry18(o_inh),
        .CTL_SPEC_genCarry18(o_gen), .CTL_saveBusy(o_busy), .CTL_saveDone(o_done)
    );

    exp_t q[$];
    int checks = 0;
    int errors = 0;
    int n = 0;
    int save_start = -1000;
    logic [SELW-1:0] m_arl = '0, m_arr = '0, m_arx = '0;

    // reference: a save started at edge s is busy after edges s..s+SAVE_CYC-1 and done after s+SAVE_CYC
    task automatic model_push();
        exp_t e;
        logic pi, busy_prev, busy;
        n++;
        e = '0;
        if (!rstn) begin
            save_start = -1000;
            m_arl = '0;
            m_arr = '0;
            m_arx = '0;
        end else begin
            pi = pcinh & xcry;
            busy_prev = (n - 1 >= save_start) && (n - 1 < save_start + SAVE_CYC);
            if (valid && pi && !busy_prev) save_start = n;
            busy = (n >= save_start) && (n < save_start + SAVE_CYC);
            if (valid) begin
                m_arl = arl;
                m_arr = arr;
                m_arx = arx;
            end
            e.arl   = m_arl;
            e.arr   = m_arr;
            e.arx   = m_arx;
            e.busy  = busy;
            e.done  = (n == save_start + SAVE_CYC);
            if (valid) begin
                e.ld[2] = (arl != 0) && !clr[2] && !busy;
                e.ld[1] = (arl != 0) && !clr[1] && !busy;
                e.ld[0] = (arr != 0) && !clr[0] && !busy;
                e.clr   = clr;
                e.arxld = (arx != 0);
                e.adc   = adc;
                e.adx   = !pi && !busy && ((ar0 && xcry) != adc);
                e.along = adlong;
                e.inh   = inh18 && !adlong;
                e.gen   = gen18 && !inh18;
            end
        end
        q.push_back(e);
    endtask

    task automatic cyc();
        @(posedge clk);
        model_push();
        #1;
    endtask

    task automatic idle();
        valid = 0; arl = 0; arr = 0; arx = 0; clr = 0; adc = 0; xcry = 0;
        gen18 = 0; inh18 = 0; adlong = 0; ar0 = 0; pcinh = 0;
    endtask

    task automatic rnd();
        valid  = $urandom_range(3) != 0;
        arl    = SELW'($urandom);
        arr    = SELW'($urandom);
        arx    = SELW'($urandom);
        clr    = 3'($urandom);
        adc    = 1'($urandom);
        xcry   = 1'($urandom);
        gen18  = 1'($urandom);
        inh18  = 1'($urandom);
        adlong = $urandom_range(3) == 0;
        ar0    = 1'($urandom);
        pcinh  = $urandom_range(5) == 0;
    endtask

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", nm, n, act, exp);
        end
    endtask

    // monitor: compares DUT outputs against the oldest pending expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("ARload", 8'(o_ld), 8'(e.ld));
                chk("ARclr", 8'(o_clr), 8'(e.clr));
                chk("ARL_SEL", 8'(o_arl), 8'(e.arl));
                chk("ARR_SEL", 8'(o_arr), 8'(e.arr));
                chk("ARX_SEL", 8'(o_arx), 8'(e.arx));
                chk("ARX_LOAD", 8'(o_arxld), 8'(e.arxld));
                chk("ADcarry36", 8'(o_adc), 8'(e.adc));
                chk("ADXcarry36", 8'(o_adx), 8'(e.adx));
                chk("ADlong", 8'(o_along), 8'(e.along));
                chk("inhibitCarry18", 8'(o_inh), 8'(e.inh));
                chk("genCarry18", 8'(o_gen), 8'(e.gen));
                chk("saveBusy", 8'(o_busy), 8'(e.busy));
                chk("saveDone", 8'(o_done), 8'(e.done));
            end
        end
    end

    initial begin
        idle();
        rstn = 0;
        #1;
        for (int i = 0; i < 3; i++) begin rnd(); cyc(); end
        rstn = 1; idle(); cyc();
        valid = 1; arl = 3; arr = 5; arx = 2; clr = 3'b001; cyc();
        idle(); cyc();
        valid = 1; xcry = 1; ar0 = 1; adc = 0; cyc();
        adc = 1; cyc();
        idle(); valid = 1; inh18 = 1; gen18 = 1; cyc();
        adlong = 1; cyc();
        idle(); valid = 1; pcinh = 1; xcry = 1; arl = 1; cyc();
        pcinh = 0; for (int i = 0; i < 4; i++) cyc();
        pcinh = 1; cyc();
        cyc();
        pcinh = 0; cyc();
        pcinh = 1; cyc();
        pcinh = 0; for (int i = 0; i < 4; i++) cyc();
        pcinh = 1; cyc();
        pcinh = 0; rstn = 0; cyc();
        rstn = 1; cyc(); cyc();
        pcinh = 1; cyc();
        pcinh = 0; for (int i = 0; i < 4; i++) cyc();
        for (int i = 0; i < 3000; i++) begin
            rnd();
            rstn = $urandom_range(63) != 0;
            cyc();
        end
        idle(); rstn = 1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard drain: got %0d pending expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
